wb_regfile: RTL and testbench

//  Write-back end of the MEM/WB pipeline interface; consumes the registered MEM/WB fields.

---
 rtl/wb_regfile_pkg.sv | 13 +
 rtl/wb_regfile_if.sv | 38 +++
 rtl/wb_regfile_ld_scoreboard.sv | 70 +++++++
 rtl/wb_regfile.sv | 52 +++++
 tb/tb_wb_regfile.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and types for the write-back stage and register file
package wb_regfile_pkg;
    localparam int XLEN       = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SB_CNT_W   = 2;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

    localparam sb_cnt_t SB_CNT_MAX = '1;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB retire fields, ID read ports, load issue and hazard/forwarding outputs
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    reg_addr_t mem_wb_rd;
    xlen_t     mem_wb_alu;
    xlen_t     mem_wb_rdata;
    logic      mem_wb_regwrite;
    logic      mem_wb_memtoreg;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    logic      rs1_used;
    logic      rs2_used;
    logic      issue_load;
    reg_addr_t issue_rd;
    xlen_t     rs1_data;
    xlen_t     rs2_data;
    logic      load_use_stall;
    logic      wb_we;
    reg_addr_t wb_rd;
    xlen_t     wb_data;
    logic      sb_overflow;
    logic      sb_underflow;

    modport master (
        output mem_wb_rd, mem_wb_alu, mem_wb_rdata, mem_wb_regwrite, mem_wb_memtoreg,
        output rs1_addr, rs2_addr, rs1_used, rs2_used, issue_load, issue_rd,
        input  rs1_data, rs2_data, load_use_stall, wb_we, wb_rd, wb_data,
        input  sb_overflow, sb_underflow
    );

    modport slave (
        input  mem_wb_rd, mem_wb_alu, mem_wb_rdata, mem_wb_regwrite, mem_wb_memtoreg,
        input  rs1_addr, rs2_addr, rs1_used, rs2_used, issue_load, issue_rd,
        output rs1_data, rs2_data, load_use_stall, wb_we, wb_rd, wb_data,
        output sb_overflow, sb_underflow
    );
endinterface

// File: rtl/wb_regfile_ld_scoreboard.sv
// wb_regfile_ld_scoreboard: per-register outstanding-load counters with sticky over/underflow.
// WB_BYPASS_EN: a load completing this cycle that empties the counter releases the reader now.
module wb_regfile_ld_scoreboard
    import wb_regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      inc_i,
    input  reg_addr_t inc_rd_i,
    input  logic      dec_i,
    input  reg_addr_t dec_rd_i,
    input  reg_addr_t rs1_i,
    input  reg_addr_t rs2_i,
    output logic      busy1_o,
    output logic      busy2_o,
    output logic      overflow_o,
    output logic      underflow_o
);
    sb_cnt_t cnt_q [NUM_REGS];
    sb_cnt_t cnt_d [NUM_REGS];
    logic    ovf_q, ovf_d, unf_q, unf_d;
    logic    inc_v, dec_v, both, clr1, clr2;

    // x0 never counts, so its counter stays at its reset value of zero
    assign inc_v = inc_i && inc_rd_i != '0;
    assign dec_v = dec_i && dec_rd_i != '0;
    assign both  = inc_v && dec_v && inc_rd_i == dec_rd_i;

`ifdef WB_BYPASS_EN
    assign clr1 = dec_v && dec_rd_i == rs1_i && cnt_q[rs1_i] == sb_cnt_t'(1);
    assign clr2 = dec_v && dec_rd_i == rs2_i && cnt_q[rs2_i] == sb_cnt_t'(1);
`else
    assign clr1 = 1'b0;
    assign clr2 = 1'b0;
`endif

    // a same-cycle issue to rsN is younger than the reader and is ignored here
    assign busy1_o     = cnt_q[rs1_i] != '0 && !clr1;
    assign busy2_o     = cnt_q[rs2_i] != '0 && !clr2;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // counter update: inc and dec of the same register cancel; saturate and flag at limits
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (inc_v && !both) begin
            if (cnt_q[inc_rd_i] == SB_CNT_MAX) ovf_d = 1'b1;
            else cnt_d[inc_rd_i] = cnt_q[inc_rd_i] + sb_cnt_t'(1);
        end
        if (dec_v && !both) begin
            if (cnt_q[dec_rd_i] == '0) unf_d = 1'b1;
            else cnt_d[dec_rd_i] = cnt_q[dec_rd_i] - sb_cnt_t'(1);
        end
    end

    // state registers; sticky flags clear only on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '{default: '0};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 32x64 register file with two read ports, load-use stall.
// WB_BYPASS_EN: reads of the register being written this cycle return the write-back value.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);
    xlen_t regs_q [NUM_REGS];
    logic  busy1, busy2;
    logic  byp1, byp2;

    assign bus.wb_we   = bus.mem_wb_regwrite && bus.mem_wb_rd != '0;
    assign bus.wb_rd   = bus.mem_wb_rd;
    assign bus.wb_data = bus.mem_wb_memtoreg ? bus.mem_wb_rdata : bus.mem_wb_alu;

`ifdef WB_BYPASS_EN
    assign byp1 = bus.wb_we && bus.wb_rd == bus.rs1_addr;
    assign byp2 = bus.wb_we && bus.wb_rd == bus.rs2_addr;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // x0 is never written and resets to zero, so it always reads as zero
    assign bus.rs1_data = byp1 ? bus.wb_data : regs_q[bus.rs1_addr];
    assign bus.rs2_data = byp2 ? bus.wb_data : regs_q[bus.rs2_addr];

    assign bus.load_use_stall = (bus.rs1_used && busy1) || (bus.rs2_used && busy2);

    // register array write; a write-back during reset is discarded
    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else if (bus.wb_we) regs_q[bus.mem_wb_rd] <= bus.wb_data;
    end

    wb_regfile_ld_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (bus.issue_load),
        .inc_rd_i    (bus.issue_rd),
        .dec_i       (bus.mem_wb_regwrite && bus.mem_wb_memtoreg),
        .dec_rd_i    (bus.mem_wb_rd),
        .rs1_i       (bus.rs1_addr),
        .rs2_i       (bus.rs2_addr),
        .busy1_o     (busy1),
        .busy2_o     (busy2),
        .overflow_o  (bus.sb_overflow),
        .underflow_o (bus.sb_underflow)
    );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random stimulus against a queue-based scoreboard and reference model
module tb_wb_regfile;
    import wb_regfile_pkg::*;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_regfile_if bus();
    wb_regfile dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit rst; reg_addr_t rd; xlen_t alu; xlen_t rdata; bit rw; bit mtr;
        reg_addr_t a1; reg_addr_t a2; bit u1; bit u2; bit il; reg_addr_t ird;
    } stim_t;

    typedef struct {
        xlen_t rs1; xlen_t rs2; bit stall; bit we; reg_addr_t rd; xlen_t wd; bit ovf; bit unf;
    } exp_t;

    exp_t  q[$];
    xlen_t m_regs [NUM_REGS];
    int    m_cnt  [NUM_REGS];
    bit    m_ovf, m_unf;
    int    checks = 0;
    int    passed = 0;

    task automatic chk(input string name, input xlen_t act, input xlen_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic xlen_t model_read(input stim_t s, input reg_addr_t a);
        bit we = s.rw && s.rd != 0;
        if (a == 0) return '0;
        if (BYP && we && s.rd == a) return s.mtr ? s.rdata : s.alu;
        return m_regs[a];
    endfunction

    // older loads still pending for the reader once any load retiring now is accounted for
    function automatic bit model_busy(input stim_t s, input reg_addr_t a);
        int done = (s.rw && s.mtr && s.rd == a && a != 0) ? 1 : 0;
        return BYP ? (m_cnt[a] - done > 0) : (m_cnt[a] > 0);
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit inc, dec;
        reset                = s.rst;
        bus.mem_wb_rd        = s.rd;
        bus.mem_wb_alu       = s.alu;
        bus.mem_wb_rdata     = s.rdata;
        bus.mem_wb_regwrite  = s.rw;
        bus.mem_wb_memtoreg  = s.mtr;
        bus.rs1_addr         = s.a1;
        bus.rs2_addr         = s.a2;
        bus.rs1_used         = s.u1;
        bus.rs2_used         = s.u2;
        bus.issue_load       = s.il;
        bus.issue_rd         = s.ird;
        if (!s.rst) begin
            e.rs1   = model_read(s, s.a1);
            e.rs2   = model_read(s, s.a2);
            e.stall = (s.u1 && model_busy(s, s.a1)) || (s.u2 && model_busy(s, s.a2));
            e.we    = s.rw && s.rd != 0;
            e.rd    = s.rd;
            e.wd    = s.mtr ? s.rdata : s.alu;
            e.ovf   = m_ovf;
            e.unf   = m_unf;
            q.push_back(e);
        end
        @(posedge clk);
        if (s.rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (s.rw && s.rd != 0) m_regs[s.rd] = s.mtr ? s.rdata : s.alu;
            inc = s.il && s.ird != 0;
            dec = s.rw && s.mtr && s.rd != 0;
            if (!(inc && dec && s.ird == s.rd)) begin
                if (inc) begin
                    if (m_cnt[s.ird] == 3) m_ovf = 1;
                    else m_cnt[s.ird]++;
                end
                if (dec) begin
                    if (m_cnt[s.rd] == 0) m_unf = 1;
                    else m_cnt[s.rd]--;
                end
            end
        end
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("rs1_data", bus.rs1_data, e.rs1);
                chk("rs2_data", bus.rs2_data, e.rs2);
                chk("load_use_stall", xlen_t'(bus.load_use_stall), xlen_t'(e.stall));
                chk("wb_we", xlen_t'(bus.wb_we), xlen_t'(e.we));
                chk("wb_rd", xlen_t'(bus.wb_rd), xlen_t'(e.rd));
                chk("wb_data", bus.wb_data, e.wd);
                chk("sb_overflow", xlen_t'(bus.sb_overflow), xlen_t'(e.ovf));
                chk("sb_underflow", xlen_t'(bus.sb_underflow), xlen_t'(e.unf));
            end
        end
    end

    initial begin
        stim_t s;
        int wait_cycles;
        s = idle(); s.rst = 1; step(s); step(s);
        s = idle(); s.a1 = 5; s.a2 = 9; s.u1 = 1; s.u2 = 1; step(s);
        s = idle(); s.rw = 1; s.rd = 5; s.alu = 64'h1234; step(s);
        s = idle(); s.a1 = 5; step(s);
        s = idle(); s.rw = 1; s.rd = 0; s.alu = 64'hFFFF; s.a1 = 0; step(s);
        s = idle(); s.a1 = 0; step(s);
        s = idle(); s.rw = 1; s.rd = 7; s.alu = 64'h77; s.il = 1; s.ird = 7; step(s);
        s = idle(); s.rw = 1; s.mtr = 1; s.rd = 7; s.rdata = 64'hAB; s.a2 = 7; step(s);
        s = idle(); s.a2 = 7; step(s);
        s = idle(); s.il = 1; s.ird = 9; step(s);
        s = idle(); s.a1 = 9; s.u1 = 1; step(s);
        s.rw = 1; s.mtr = 1; s.rd = 9; s.rdata = 64'h99; step(s);
        s = idle(); s.a1 = 9; s.u1 = 1; step(s);
        s = idle(); s.il = 1; s.ird = 3; step(s); step(s);
        s = idle(); s.a1 = 3; s.u1 = 1; s.rw = 1; s.mtr = 1; s.rd = 3; s.rdata = 64'h31; step(s);
        s.rdata = 64'h32; step(s);
        s = idle(); s.a1 = 3; s.u1 = 1; step(s);
        s = idle(); s.il = 1; s.ird = 4; repeat (4) step(s);
        s = idle(); s.a2 = 4; s.u2 = 1; step(s);
        s = idle(); s.rw = 1; s.mtr = 1; s.rd = 6; s.rdata = 64'h66; step(s);
        s = idle(); step(s);
        s = idle(); s.rst = 1; step(s);
        s = idle(); s.a1 = 4; s.u1 = 1; s.a2 = 6; step(s);
        for (int n = 0; n < 600; n++) begin
            s.rst   = ($urandom_range(0, 79) == 0);
            s.rd    = reg_addr_t'($urandom_range(0, 7));
            s.alu   = {$urandom, $urandom};
            s.rdata = {$urandom, $urandom};
            s.rw    = $urandom_range(0, 1) == 1;
            s.mtr   = $urandom_range(0, 1) == 1;
            s.a1    = reg_addr_t'($urandom_range(0, 7));
            s.a2    = reg_addr_t'($urandom_range(0, 7));
            s.u1    = $urandom_range(0, 1) == 1;
            s.u2    = $urandom_range(0, 1) == 1;
            s.il    = $urandom_range(0, 2) == 0;
            s.ird   = reg_addr_t'($urandom_range(0, 7));
            step(s);
        end
        s = idle(); step(s);
        wait_cycles = 0;
        while (q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
